// File: rtl/tcb_arb_pkg.sv
// Shared types for the TCB arbiter: FSM state encoding and response-queue entry.
// Build option TCB_ARB_LOCK_EN adds the LOCK state.
package tcb_arb_pkg;

  // Wide enough for the largest supported manager count (8).
  localparam int IDX_W = 3;

`ifdef TCB_ARB_LOCK_EN
  typedef enum logic [1:0] {ST_ARB, ST_HOLD, ST_LOCK} state_t;
`else
  typedef enum logic [1:0] {ST_ARB, ST_HOLD} state_t;
`endif

  typedef struct packed {
    logic             vld;
    logic [IDX_W-1:0] idx;
  } rsp_ent_t;

endpackage

// File: rtl/tcb_arb_if.sv
// TCB bus bundle with N parallel lanes; a manager port uses N = MPN, a subordinate port N = 1.
interface tcb_arb_if #(
  parameter int N   = 1,
  parameter int ABW = 32,
  parameter int DBW = 32,
  parameter int SLW = 8
);
  localparam int BEW = DBW/SLW;

  logic [N-1:0]     vld;
  logic [N-1:0]     wen;
  logic [N-1:0]     lck;
  logic [N-1:0]     rpt;
  logic [N*ABW-1:0] adr;
  logic [N*BEW-1:0] ben;
  logic [N*DBW-1:0] wdt;
  logic [N*DBW-1:0] rdt;
  logic [N-1:0]     err;
  logic [N-1:0]     rdy;

  modport master (output vld, wen, lck, rpt, adr, ben, wdt, input  rdt, err, rdy);
  modport slave  (input  vld, wen, lck, rpt, adr, ben, wdt, output rdt, err, rdy);
endinterface

// File: rtl/tcb_arb_rr.sv
// Round-robin picker: first requesting index at or after ptr, wrapping modulo MPN.
module tcb_arb_rr #(
  parameter int MPN = 2
) (
  input  logic [MPN-1:0]         req,
  input  logic [$clog2(MPN)-1:0] ptr,
  output logic [$clog2(MPN)-1:0] idx,
  output logic                   any
);
  localparam int IW = $clog2(MPN);

  always_comb begin
    int j;
    logic [IW-1:0] js;
    j   = 0;
    js  = '0;
    idx = ptr;
    any = |req;
    // Scan farthest-first so the candidate closest to ptr wins.
    for (int k = MPN-1; k >= 0; k--) begin
      j  = (int'(ptr) + k) % MPN;
      js = IW'(j);
      if (req[js]) idx = js;
    end
  end
endmodule

// File: rtl/tcb_arb.sv
// Round-robin arbiter sharing one TCB subordinate among MPN managers, with delayed response routing.
// Build option TCB_ARB_LOCK_EN enables locked (back-to-back exclusive) sequences.
module tcb_arb
  import tcb_arb_pkg::*;
#(
  parameter int MPN = 2,
  parameter int ABW = 32,
  parameter int DBW = 32,
  parameter int SLW = 8,
  parameter int DLY = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  tcb_arb_if.slave               man,
  tcb_arb_if.master              sub,
  output logic [$clog2(MPN)-1:0] gnt
);
  localparam int BEW = DBW/SLW;
  localparam int IW  = $clog2(MPN);
  localparam int QD  = (DLY > 0) ? DLY : 1;

  state_t        state_reg;
  logic [IW-1:0] ptr_reg;
  logic [IW-1:0] gnt_reg;
  logic [IW-1:0] rr_idx;
  logic [IW-1:0] gnt_inc;
  logic          rr_any;
  logic          trn;
  rsp_ent_t      head;

  logic [ABW-1:0] adr_a [MPN];
  logic [BEW-1:0] ben_a [MPN];
  logic [DBW-1:0] wdt_a [MPN];

  tcb_arb_rr #(.MPN(MPN)) u_rr (
    .req (man.vld),
    .ptr (ptr_reg),
    .idx (rr_idx),
    .any (rr_any)
  );

  // Live choice while arbitrating; frozen choice while holding or locked.
  assign gnt     = (state_reg == ST_ARB) ? rr_idx : gnt_reg;
  assign gnt_inc = (int'(gnt) == MPN-1) ? '0 : gnt + IW'(1);

  genvar gi;
  generate
    for (gi = 0; gi < MPN; gi++) begin : g_man
      assign adr_a[gi] = man.adr[gi*ABW +: ABW];
      assign ben_a[gi] = man.ben[gi*BEW +: BEW];
      assign wdt_a[gi] = man.wdt[gi*DBW +: DBW];
      assign man.rdy[gi] = sub.rdy[0] & (gnt == IW'(gi));
      assign man.rdt[gi*DBW +: DBW] = (head.vld && head.idx == IDX_W'(gi)) ? sub.rdt : '0;
      assign man.err[gi] = head.vld && head.idx == IDX_W'(gi) && sub.err[0];
    end
  endgenerate

  assign sub.vld = (state_reg == ST_ARB) ? rr_any : man.vld[gnt];
  assign sub.wen = man.wen[gnt];
  assign sub.lck = man.lck[gnt];
  assign sub.rpt = man.rpt[gnt];
  assign sub.adr = adr_a[gnt];
  assign sub.ben = ben_a[gnt];
  assign sub.wdt = wdt_a[gnt];

  assign trn = sub.vld[0] & sub.rdy[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_ARB;
      ptr_reg   <= '0;
      gnt_reg   <= '0;
    end else begin
      if (trn) ptr_reg <= gnt_inc;
      case (state_reg)
        ST_ARB: begin
          gnt_reg <= gnt;
          if (sub.vld[0] && !sub.rdy[0]) state_reg <= ST_HOLD;
`ifdef TCB_ARB_LOCK_EN
          else if (trn && sub.lck[0]) state_reg <= ST_LOCK;
`endif
        end
        ST_HOLD: begin
`ifdef TCB_ARB_LOCK_EN
          if (trn) state_reg <= sub.lck[0] ? ST_LOCK : ST_ARB;
`else
          if (trn) state_reg <= ST_ARB;
`endif
        end
`ifdef TCB_ARB_LOCK_EN
        ST_LOCK: begin
          if (trn && !sub.lck[0]) state_reg <= ST_ARB;
        end
`endif
        default: state_reg <= ST_ARB;
      endcase
    end
  end

  // Response queue: one entry per cycle of subordinate latency, head is the oldest.
  generate
    if (DLY == 0) begin : g_nodly
      assign head.vld = trn;
      assign head.idx = IDX_W'(gnt);
    end else begin : g_dly
      rsp_ent_t rsp_q [QD];
      for (gi = 0; gi < DLY; gi++) begin : g_q
        always_ff @(posedge clk or posedge rst) begin
          if (rst) rsp_q[gi] <= '0;
          else if (gi == 0) rsp_q[gi] <= {trn, IDX_W'(gnt)};
          else rsp_q[gi] <= rsp_q[(gi > 0) ? gi-1 : 0];
        end
      end
      assign head = rsp_q[DLY-1];
    end
  endgenerate
endmodule
